alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs id_valid 1, id_rs_data 32, id_rt_data 32, id_imm 32, id_shamt 5, id_rs_addr 5, id_rt_addr 5, id_rd_addr 5: decoded instruction fields.
REQ-004 SHALL have inputs id_alusrc_a 1 (1 = shamt as A), id_alusrc_b 1 (1 = imm as B), id_alufun 6, id_sign 1, id_regwrite 1, id_memread 1.
REQ-005 SHALL have inputs stall_in 1 (downstream hold) and flush 1 (kill instruction being captured).
REQ-006 SHALL have inputs mem_regwrite 1, mem_rd 5, mem_result 32, wb_regwrite 1, wb_rd 5, wb_result 32 as forwarding sources.
REQ-007 SHALL have outputs ex_valid 1, ex_inA 32, ex_inB 32, ex_alufun 6, ex_sign 1, ex_rd 5, ex_regwrite 1, ex_memread 1, ex_rt_fwd 32 (forwarded rt for stores), and hazard_stall 1.

Function
REQ-008 SHALL hold one pipeline register (ID/EX) of all id_* fields except rs/rt data, which are latched raw.
REQ-009 Register update priority per edge SHALL be: stall_in hold > flush bubble > hazard bubble > capture.
REQ-010 Hold: every register unchanged.
REQ-011 Bubble: ex_valid, ex_regwrite, ex_memread cleared to 0; other fields don't-care but ex_alufun forced 0.
REQ-012 Capture: all fields loaded from id_*; ex_valid <= id_valid; ex_regwrite/ex_memread gated by id_valid.
REQ-013 hazard_stall SHALL be combinational: ex_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs_addr | (ex_rd==id_rt_addr & ~id_alusrc_b)) & id_valid.
REQ-014 hazard_stall SHALL be forced 0 while stall_in or flush is 1.
REQ-015 Forwarded rs/rt SHALL be combinational from latched raw data: mem match (mem_regwrite & mem_rd!=0 & mem_rd==latched addr) first, else wb match, else raw.
REQ-016 Register address 0 SHALL never be forwarded; raw value passes.
REQ-017 ex_inA SHALL be {27'b0, latched shamt} when latched alusrc_a=1, else forwarded rs.
REQ-018 ex_inB SHALL be latched imm when latched alusrc_b=1, else forwarded rt; ex_rt_fwd always forwarded rt.
REQ-019 Latency: id_* captured at edge N appear on ex_* after edge N; forwarding adds no cycle.
REQ-020 Simultaneous mem and wb match on same register SHALL select mem_result.
REQ-021 id_valid=0 with no stall SHALL load a bubble-equivalent (ex_valid=0, side-effect controls 0).

Reset
REQ-022 rst_n low SHALL immediately clear all registers: ex_valid 0, ex_alufun 0, ex_sign 0, ex_rd 0, ex_regwrite 0, ex_memread 0, latched data/imm/shamt 0.
REQ-023 With rst_n low, ex_inA/ex_inB SHALL equal forwarding result of zeroed latches (0 absent forwarding); hazard_stall 0.
REQ-024 Reset release mid-stream SHALL resume with a capture on the first rising edge where rst_n is high.

Configuration
REQ-025 Macro ALU_FWD_WB_EN defined: WB forwarding path per REQ-015 compiled in.
REQ-026 Macro ALU_FWD_WB_EN undefined: wb_* inputs ignored, only mem forwarding; register file SHALL be write-before-read.

Verification
REQ-027 add: capture rs=3 (0x10), rt=4 (0x20), no hazards -> next cycle ex_inA=0x10, ex_inB=0x20, ex_alufun=id_alufun, ex_valid=1.
REQ-028 mem_rd=3 mem_result=0xAAAA, wb_rd=3 wb_result=0xBBBB -> ex_inA=0xAAAA; with mem_regwrite=0 -> 0xBBBB (0x10 if ALU_FWD_WB_EN undefined).
REQ-029 lw to r5 in EX, id_rs_addr=5 -> hazard_stall=1, next cycle ex_valid=0, ex_regwrite=0; same with ex_rd=0 -> hazard_stall=0.
REQ-030 sll: id_alusrc_a=1, id_shamt=7, rt=0x1 -> ex_inA=0x7, ex_inB=0x1.
REQ-031 stall_in=1 with flush=1 for 2 cycles -> ex_* unchanged; flush alone -> ex_valid=0 next cycle.
REQ-032 rst_n pulsed low mid-cycle with ex_valid=1 -> ex_valid, ex_regwrite drop to 0 before next clk edge.

Source files
------------

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX pipeline register with operand forwarding and load-use hazard detect
//
// Purpose:
//   Holds one instruction between decode and execute. Register operands are
//   latched raw and forwarded combinationally from the MEM and WB stages, so
//   forwarding adds no cycle. A load in EX whose destination is read by the
//   instruction in ID raises hazard_stall, and a bubble is inserted.
//
// Configuration:
//   ALU_FWD_WB_EN  defined   : WB result is a forwarding source (behind MEM).
//                  undefined : wb_* inputs are ignored; only MEM forwarding is
//                              used, so the register file must be write-before-read.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   id_*                         decoded instruction fields from ID
//   stall_in                     downstream hold (freezes every register)
//   flush                        kill the instruction being captured
//   mem_regwrite/mem_rd/mem_result  MEM stage forwarding source
//   wb_regwrite/wb_rd/wb_result     WB stage forwarding source
//   ex_*                         operands and controls presented to EX
//   ex_rt_fwd                    forwarded rt value (store data)
//   hazard_stall                 load-use hazard, asks upstream to hold ID

module alu_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_alusrc_a,
  input  logic        id_alusrc_b,
  input  logic [5:0]  id_alufun,
  input  logic        id_sign,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        stall_in,
  input  logic        flush,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  output logic        ex_valid,
  output logic [31:0] ex_inA,
  output logic [31:0] ex_inB,
  output logic [5:0]  ex_alufun,
  output logic        ex_sign,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic [31:0] ex_rt_fwd,
  output logic        hazard_stall
);

  logic [31:0] rs_data_q;
  logic [31:0] rt_data_q;
  logic [31:0] imm_q;
  logic [4:0]  shamt_q;
  logic [4:0]  rs_addr_q;
  logic [4:0]  rt_addr_q;
  logic        alusrc_a_q;
  logic        alusrc_b_q;
  logic        hazard_raw;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  // Load-use: the loaded value is not available until after EX, so the
  // consumer must wait. rt only matters when it is actually read as B.
  assign hazard_raw = ex_valid & ex_memread & (ex_rd != 5'd0) & id_valid &
                      ((ex_rd == id_rs_addr) | ((ex_rd == id_rt_addr) & ~id_alusrc_b));

  // A held or flushed capture never needs an extra bubble.
  assign hazard_stall = hazard_raw & ~stall_in & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_alufun   <= 6'd0;
      ex_sign     <= 1'b0;
      ex_rd       <= 5'd0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      rs_data_q   <= 32'd0;
      rt_data_q   <= 32'd0;
      imm_q       <= 32'd0;
      shamt_q     <= 5'd0;
      rs_addr_q   <= 5'd0;
      rt_addr_q   <= 5'd0;
      alusrc_a_q  <= 1'b0;
      alusrc_b_q  <= 1'b0;
    end else if (stall_in) begin
      // hold: every register keeps its value
    end else if (flush || hazard_raw) begin
      // bubble: only the side-effect controls matter; data fields are left as-is
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_alufun   <= 6'd0;
    end else begin
      ex_valid    <= id_valid;
      ex_alufun   <= id_alufun;
      ex_sign     <= id_sign;
      ex_rd       <= id_rd_addr;
      ex_regwrite <= id_valid & id_regwrite;
      ex_memread  <= id_valid & id_memread;
      rs_data_q   <= id_rs_data;
      rt_data_q   <= id_rt_data;
      imm_q       <= id_imm;
      shamt_q     <= id_shamt;
      rs_addr_q   <= id_rs_addr;
      rt_addr_q   <= id_rt_addr;
      alusrc_a_q  <= id_alusrc_a;
      alusrc_b_q  <= id_alusrc_b;
    end
  end

  // Forwarding: WB applied first, MEM afterwards so the younger result wins.
  // r0 is hard-wired zero and is never forwarded.
`ifdef ALU_FWD_WB_EN
  always_comb begin
    rs_fwd = rs_data_q;
    rt_fwd = rt_data_q;
    if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs_addr_q)) rs_fwd = wb_result;
    if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rt_addr_q)) rt_fwd = wb_result;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rs_addr_q)) rs_fwd = mem_result;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rt_addr_q)) rt_fwd = mem_result;
  end
`else
  logic wb_unused;
  assign wb_unused = ^{wb_regwrite, wb_rd, wb_result};

  always_comb begin
    rs_fwd = rs_data_q;
    rt_fwd = rt_data_q;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rs_addr_q)) rs_fwd = mem_result;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rt_addr_q)) rt_fwd = mem_result;
  end
`endif

  assign ex_inA    = alusrc_a_q ? {27'd0, shamt_q} : rs_fwd;
  assign ex_inB    = alusrc_b_q ? imm_q : rt_fwd;
  assign ex_rt_fwd = rt_fwd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed table-driven bench for alu_operand_stage

module tb_alu_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs_addr, id_rt_addr, id_rd_addr;
  logic        id_alusrc_a, id_alusrc_b;
  logic [5:0]  id_alufun;
  logic        id_sign, id_regwrite, id_memread;
  logic        stall_in, flush;
  logic        mem_regwrite;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        ex_valid;
  logic [31:0] ex_inA, ex_inB, ex_rt_fwd;
  logic [5:0]  ex_alufun;
  logic        ex_sign;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread;
  logic        hazard_stall;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_alusrc_a(id_alusrc_a), .id_alusrc_b(id_alusrc_b), .id_alufun(id_alufun),
    .id_sign(id_sign), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .stall_in(stall_in), .flush(flush),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_inA(ex_inA), .ex_inB(ex_inB), .ex_alufun(ex_alufun),
    .ex_sign(ex_sign), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_rt_fwd(ex_rt_fwd), .hazard_stall(hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  shamt, rs_addr, rt_addr, rd_addr;
    logic        asa, asb;
    logic [5:0]  fun;
    logic        sgn, rw, mr, fl;
    logic        mrw;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        wrw;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic        e_hz;
    logic        chk_data;
    logic        e_valid;
    logic [31:0] e_a, e_b, e_rtf;
    logic [5:0]  e_fun;
    logic [4:0]  e_rd;
    logic        e_rw, e_mr, e_sign;
  } vec_t;

  localparam int NV = 20;
  vec_t vt[NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0; id_alusrc_a = 0; id_alusrc_b = 0;
    id_alufun = 0; id_sign = 0; id_regwrite = 0; id_memread = 0;
    stall_in = 0; flush = 0;
    mem_regwrite = 0; mem_rd = 0; mem_result = 0;
    wb_regwrite = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    id_valid = v.valid; id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm = v.imm;
    id_shamt = v.shamt; id_rs_addr = v.rs_addr; id_rt_addr = v.rt_addr; id_rd_addr = v.rd_addr;
    id_alusrc_a = v.asa; id_alusrc_b = v.asb; id_alufun = v.fun; id_sign = v.sgn;
    id_regwrite = v.rw; id_memread = v.mr; flush = v.fl; stall_in = 0;
    mem_regwrite = v.mrw; mem_rd = v.mrd; mem_result = v.mres;
    wb_regwrite = v.wrw; wb_rd = v.wrd; wb_result = v.wres;
  endtask

  initial begin
    logic [31:0] wb_exp;
`ifdef ALU_FWD_WB_EN
    wb_exp = 32'hBBBB;
`else
    wb_exp = 32'h10;
`endif
    // add r6 = r3 + r4
    vt[0]  = '{valid:1, rs_addr:3, rs_data:32'h10, rt_addr:4, rt_data:32'h20, rd_addr:6, fun:6'h20, sgn:1, rw:1,
               chk_data:1, e_valid:1, e_a:32'h10, e_b:32'h20, e_rtf:32'h20, e_fun:6'h20, e_rd:6, e_rw:1, e_sign:1, default:'0};
    // mem and wb both hit r3: mem wins
    vt[1]  = '{valid:1, rs_addr:3, rs_data:32'h10, rt_addr:4, rt_data:32'h20, rd_addr:6, fun:6'h20, rw:1,
               mrw:1, mrd:3, mres:32'hAAAA, wrw:1, wrd:3, wres:32'hBBBB,
               chk_data:1, e_valid:1, e_a:32'hAAAA, e_b:32'h20, e_rtf:32'h20, e_fun:6'h20, e_rd:6, e_rw:1, default:'0};
    // only wb hits r3
    vt[2]  = '{valid:1, rs_addr:3, rs_data:32'h10, rt_addr:4, rt_data:32'h20, rd_addr:6, fun:6'h20, rw:1,
               mrd:3, mres:32'hAAAA, wrw:1, wrd:3, wres:32'hBBBB,
               chk_data:1, e_valid:1, e_a:wb_exp, e_b:32'h20, e_rtf:32'h20, e_fun:6'h20, e_rd:6, e_rw:1, default:'0};
    // mem hits rt
    vt[3]  = '{valid:1, rs_addr:3, rs_data:32'h10, rt_addr:4, rt_data:32'h20, rd_addr:6, fun:6'h20, rw:1,
               mrw:1, mrd:4, mres:32'h1234,
               chk_data:1, e_valid:1, e_a:32'h10, e_b:32'h1234, e_rtf:32'h1234, e_fun:6'h20, e_rd:6, e_rw:1, default:'0};
    // r0 never forwarded
    vt[4]  = '{valid:1, rs_addr:0, rs_data:32'h55, rt_addr:4, rt_data:32'h20, rd_addr:6, fun:6'h20, rw:1,
               mrw:1, mrd:0, mres:32'h999, wrw:1, wrd:0, wres:32'h888,
               chk_data:1, e_valid:1, e_a:32'h55, e_b:32'h20, e_rtf:32'h20, e_fun:6'h20, e_rd:6, e_rw:1, default:'0};
    // sll: shamt as A
    vt[5]  = '{valid:1, asa:1, shamt:7, rs_data:32'hDEAD, rt_addr:2, rt_data:32'h1, rd_addr:9, rw:1,
               chk_data:1, e_valid:1, e_a:32'h7, e_b:32'h1, e_rtf:32'h1, e_rd:9, e_rw:1, default:'0};
    // imm as B, rt still forwarded for ex_rt_fwd
    vt[6]  = '{valid:1, asb:1, imm:32'hFFFF_FFF0, rs_addr:3, rs_data:32'h10, rt_addr:4, rt_data:32'h20, rd_addr:6, fun:6'h21, rw:1,
               mrw:1, mrd:4, mres:32'h77,
               chk_data:1, e_valid:1, e_a:32'h10, e_b:32'hFFFF_FFF0, e_rtf:32'h77, e_fun:6'h21, e_rd:6, e_rw:1, default:'0};
    // lw r5
    vt[7]  = '{valid:1, asb:1, imm:4, rs_addr:1, rs_data:32'h100, rt_addr:5, rd_addr:5, fun:6'h21, rw:1, mr:1,
               chk_data:1, e_valid:1, e_a:32'h100, e_b:4, e_rd:5, e_fun:6'h21, e_rw:1, e_mr:1, default:'0};
    // consumer of r5 -> load-use bubble
    vt[8]  = '{valid:1, rs_addr:5, rs_data:32'h30, rt_addr:6, rt_data:32'h40, rd_addr:7, fun:6'h20, rw:1,
               e_hz:1, default:'0};
    // lw r0
    vt[9]  = '{valid:1, asb:1, imm:8, rs_addr:1, rs_data:32'h100, rd_addr:0, fun:6'h21, rw:1, mr:1,
               chk_data:1, e_valid:1, e_a:32'h100, e_b:8, e_fun:6'h21, e_rw:1, e_mr:1, default:'0};
    // reads r0 behind lw r0: no hazard
    vt[10] = '{valid:1, rs_addr:0, rs_data:32'h3, rt_addr:7, rt_data:32'h9, rd_addr:7, fun:6'h20, rw:1,
               chk_data:1, e_valid:1, e_a:32'h3, e_b:32'h9, e_rtf:32'h9, e_fun:6'h20, e_rd:7, e_rw:1, default:'0};
    // lw r8
    vt[11] = '{valid:1, asb:1, imm:32'hC, rs_addr:1, rs_data:32'h100, rt_addr:8, rd_addr:8, fun:6'h21, rw:1, mr:1,
               chk_data:1, e_valid:1, e_a:32'h100, e_b:32'hC, e_rd:8, e_fun:6'h21, e_rw:1, e_mr:1, default:'0};
    // rt=r8 but imm used as B: no hazard
    vt[12] = '{valid:1, asb:1, imm:32'h40, rs_addr:1, rs_data:32'h5, rt_addr:8, rd_addr:8, fun:6'h08, rw:1,
               chk_data:1, e_valid:1, e_a:32'h5, e_b:32'h40, e_rd:8, e_fun:6'h08, e_rw:1, default:'0};
    vt[13] = vt[11];
    // rt=r8 read as B: hazard
    vt[14] = '{valid:1, rs_addr:1, rs_data:32'h5, rt_addr:8, rt_data:32'h66, rd_addr:3, fun:6'h20, rw:1,
               e_hz:1, default:'0};
    // lw r9
    vt[15] = '{valid:1, asb:1, imm:32'h10, rs_addr:1, rs_data:32'h100, rt_addr:9, rd_addr:9, fun:6'h21, rw:1, mr:1,
               chk_data:1, e_valid:1, e_a:32'h100, e_b:32'h10, e_rd:9, e_fun:6'h21, e_rw:1, e_mr:1, default:'0};
    // invalid id reading r9: no hazard, controls gated off
    vt[16] = '{valid:0, rs_addr:9, rs_data:32'h1, rd_addr:4, rw:1, mr:1, default:'0};
    // flush kills a valid add
    vt[17] = '{valid:1, fl:1, rs_addr:3, rs_data:32'h10, rt_addr:4, rt_data:32'h20, rd_addr:6, fun:6'h20, rw:1,
               default:'0};
    // lw r10
    vt[18] = '{valid:1, asb:1, imm:0, rs_addr:1, rs_data:32'h100, rt_addr:10, rd_addr:10, fun:6'h21, rw:1, mr:1,
               chk_data:1, e_valid:1, e_a:32'h100, e_b:0, e_rd:10, e_fun:6'h21, e_rw:1, e_mr:1, default:'0};
    // hazard masked by flush
    vt[19] = '{valid:1, fl:1, rs_addr:10, rs_data:32'h1, rd_addr:2, fun:6'h20, rw:1, default:'0};

    // reset state
    drive_idle();
    rst_n = 1'b0;
    mem_regwrite = 1; mem_rd = 0; mem_result = 32'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_inA", ex_inA, 32'd0);
    chk("rst_inB", ex_inB, 32'd0);
    chk("rst_alufun", 32'(ex_alufun), 32'd0);
    chk("rst_regwrite", 32'(ex_regwrite), 32'd0);
    chk("rst_hazard", 32'(hazard_stall), 32'd0);
    rst_n = 1'b1;
    drive_idle();

    for (int i = 0; i < NV; i++) begin
      drive_vec(vt[i]);
      #2;
      chk($sformatf("v%0d_hazard", i), 32'(hazard_stall), 32'(vt[i].e_hz));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(vt[i].e_valid));
      chk($sformatf("v%0d_regwrite", i), 32'(ex_regwrite), 32'(vt[i].e_rw));
      chk($sformatf("v%0d_memread", i), 32'(ex_memread), 32'(vt[i].e_mr));
      chk($sformatf("v%0d_alufun", i), 32'(ex_alufun), 32'(vt[i].e_fun));
      if (vt[i].chk_data) begin
        chk($sformatf("v%0d_inA", i), ex_inA, vt[i].e_a);
        chk($sformatf("v%0d_inB", i), ex_inB, vt[i].e_b);
        chk($sformatf("v%0d_rt_fwd", i), ex_rt_fwd, vt[i].e_rtf);
        chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vt[i].e_rd));
        chk($sformatf("v%0d_sign", i), 32'(ex_sign), 32'(vt[i].e_sign));
      end
    end

    // stall_in with flush holds everything, and masks the load-use hazard
    drive_idle();
    id_valid = 1; id_memread = 1; id_regwrite = 1; id_rd_addr = 11; id_alufun = 6'h21;
    id_rs_addr = 1; id_rs_data = 32'h100; id_alusrc_b = 1; id_imm = 4;
    @(posedge clk);
    #1;
    chk("st_cap_valid", 32'(ex_valid), 32'd1);
    drive_idle();
    stall_in = 1; flush = 1;
    id_valid = 1; id_rs_addr = 11; id_rs_data = 32'h999; id_regwrite = 1; id_alufun = 6'h20; id_rd_addr = 3;
    #1;
    chk("st_hazard_masked", 32'(hazard_stall), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("st%0d_valid", c), 32'(ex_valid), 32'd1);
      chk($sformatf("st%0d_memread", c), 32'(ex_memread), 32'd1);
      chk($sformatf("st%0d_rd", c), 32'(ex_rd), 32'd11);
      chk($sformatf("st%0d_alufun", c), 32'(ex_alufun), 32'h21);
      chk($sformatf("st%0d_inA", c), ex_inA, 32'h100);
      chk($sformatf("st%0d_inB", c), ex_inB, 32'h4);
    end
    stall_in = 0;
    #1;
    chk("fl_hazard_masked", 32'(hazard_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_regwrite", 32'(ex_regwrite), 32'd0);

    // asynchronous reset mid-cycle, then capture on the first edge after release
    drive_idle();
    id_valid = 1; id_rs_addr = 3; id_rs_data = 32'h10; id_rt_addr = 4; id_rt_data = 32'h20;
    id_rd_addr = 6; id_regwrite = 1; id_alufun = 6'h20;
    @(posedge clk);
    #1;
    chk("ar_pre_valid", 32'(ex_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(ex_valid), 32'd0);
    chk("ar_regwrite", 32'(ex_regwrite), 32'd0);
    chk("ar_inA", ex_inA, 32'd0);
    chk("ar_inB", ex_inB, 32'd0);
    chk("ar_hazard", 32'(hazard_stall), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_resume_valid", 32'(ex_valid), 32'd1);
    chk("ar_resume_inA", ex_inA, 32'h10);
    chk("ar_resume_inB", ex_inB, 32'h20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
